// File: rtl/alu_output_register_pattern_detect.sv
// P register stage behind the SIMD ALU: registers sum and lane carries, runs the
// masked pattern / inverted-pattern detector and derives overflow/underflow flags.
module alu_output_register_pattern_detect #(
    parameter logic [1:0] AUTORESET_PATDET = 2'b00,
    localparam int unsigned DW = 48,
    localparam int unsigned CW = 8,
    localparam int unsigned RW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          CEP,
    input  logic          RSTP,
    input  logic [1:0]    USE_SIMD,
    input  logic [DW-1:0] S,
    input  logic          COUT,
    input  logic [RW-1:0] result_SIMD_carry_out,
    input  logic [DW-1:0] PATTERN,
    input  logic [DW-1:0] MASK,
    output logic [DW-1:0] P,
    output logic [CW-1:0] CARRYOUT,
    output logic          PATTERNDETECT,
    output logic          PATTERNBDETECT,
    output logic          PATTERNDETECT_PAST,
    output logic          PATTERNBDETECT_PAST,
    output logic          OVERFLOW,
    output logic          UNDERFLOW
);

    logic          det;
    logic          detb;
    logic          auto_rst;
    logic [CW-1:0] cin_next;
    logic          unused_odd_carries;

    // Masked compare against the pattern and its complement
    assign det  = &(~(S ^ PATTERN) | MASK);
    assign detb = &((S ^ PATTERN) | MASK);

    // Odd carry bits are intermediate segment carries, never exported
    assign unused_odd_carries = ^{result_SIMD_carry_out[15], result_SIMD_carry_out[13],
                                  result_SIMD_carry_out[11], result_SIMD_carry_out[9],
                                  result_SIMD_carry_out[7],  result_SIMD_carry_out[5],
                                  result_SIMD_carry_out[3],  result_SIMD_carry_out[1]};

    // Each lane's carry lands on the top CARRYOUT bit of that lane
    always_comb begin
        cin_next = '0;
        case (USE_SIMD)
            2'b00: begin
                cin_next[7] = COUT;
            end
            2'b01: begin
                cin_next[3] = result_SIMD_carry_out[6];
                cin_next[7] = result_SIMD_carry_out[14];
            end
            2'b10: begin
                cin_next[1] = result_SIMD_carry_out[2];
                cin_next[3] = result_SIMD_carry_out[6];
                cin_next[5] = result_SIMD_carry_out[10];
                cin_next[7] = result_SIMD_carry_out[14];
            end
            default: begin
                for (int k = 0; k < 8; k++) begin
                    cin_next[k] = result_SIMD_carry_out[2*k];
                end
            end
        endcase
    end

    // Mode 2'b11 is treated as no auto-reset
    assign auto_rst = ((AUTORESET_PATDET == 2'b01) &&  PATTERNDETECT) ||
                      ((AUTORESET_PATDET == 2'b10) && !PATTERNDETECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            P                   <= '0;
            CARRYOUT            <= '0;
            PATTERNDETECT       <= 1'b0;
            PATTERNBDETECT      <= 1'b0;
            PATTERNDETECT_PAST  <= 1'b0;
            PATTERNBDETECT_PAST <= 1'b0;
        end else if (RSTP) begin
            P                   <= '0;
            CARRYOUT            <= '0;
            PATTERNDETECT       <= 1'b0;
            PATTERNBDETECT      <= 1'b0;
            PATTERNDETECT_PAST  <= 1'b0;
            PATTERNBDETECT_PAST <= 1'b0;
        end else if (CEP) begin
            if (auto_rst) begin
                P        <= '0;
                CARRYOUT <= '0;
            end else begin
                P        <= S;
                CARRYOUT <= cin_next;
            end
            PATTERNDETECT       <= det;
            PATTERNBDETECT      <= detb;
            PATTERNDETECT_PAST  <= PATTERNDETECT;
            PATTERNBDETECT_PAST <= PATTERNBDETECT;
        end
    end

    assign OVERFLOW  = PATTERNDETECT_PAST  & ~PATTERNDETECT & ~PATTERNBDETECT;
    assign UNDERFLOW = PATTERNBDETECT_PAST & ~PATTERNDETECT & ~PATTERNBDETECT;

endmodule

// File: tb/tb_alu_output_register_pattern_detect.sv
// Bench: three DUTs (auto-reset modes 00/01/10) on shared stimulus, checked each
// cycle against a behavioural model, plus hand-computed directed expectations.
module tb_alu_output_register_pattern_detect;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cep;
    logic        rstp;
    logic [1:0]  use_simd;
    logic [47:0] s;
    logic        cout;
    logic [15:0] rsc;
    logic [47:0] pattern;
    logic [47:0] mask;

    logic [2:0][47:0] p_o;
    logic [2:0][7:0]  co_o;
    logic [2:0]       pd_o, pbd_o, pdp_o, pbdp_o, ovf_o, unf_o;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        alu_output_register_pattern_detect #(.AUTORESET_PATDET(2'(g))) u_dut (
            .clk                   (clk),
            .rst_n                 (rst_n),
            .CEP                   (cep),
            .RSTP                  (rstp),
            .USE_SIMD              (use_simd),
            .S                     (s),
            .COUT                  (cout),
            .result_SIMD_carry_out (rsc),
            .PATTERN               (pattern),
            .MASK                  (mask),
            .P                     (p_o[g]),
            .CARRYOUT              (co_o[g]),
            .PATTERNDETECT         (pd_o[g]),
            .PATTERNBDETECT        (pbd_o[g]),
            .PATTERNDETECT_PAST    (pdp_o[g]),
            .PATTERNBDETECT_PAST   (pbdp_o[g]),
            .OVERFLOW              (ovf_o[g]),
            .UNDERFLOW             (unf_o[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: unmasked bits of S must equal pattern (or its complement)
    function automatic bit f_det(input logic [47:0] sv, input logic [47:0] pv, input logic [47:0] mv);
        return (sv & ~mv) == (pv & ~mv);
    endfunction

    function automatic bit f_detb(input logic [47:0] sv, input logic [47:0] pv, input logic [47:0] mv);
        return (sv & ~mv) == (~pv & ~mv);
    endfunction

    // Lane n of L lanes owns the top CARRYOUT bit of its 8/L-bit slot
    function automatic logic [7:0] f_cin(input logic [1:0] mode, input logic [15:0] r, input logic c);
        logic [7:0] v;
        int lanes;
        int stride;
        int b;
        v = '0;
        lanes = 1 << (2 * int'(mode));
        if (mode == 2'b11) lanes = 8;
        else if (mode == 2'b10) lanes = 4;
        else if (mode == 2'b01) lanes = 2;
        else lanes = 1;
        stride = 8 / lanes;
        for (int k = 0; k < lanes; k++) begin
            b = stride * (k + 1) - 1;
            v[b] = (lanes == 1) ? c : r[2*b];
        end
        return v;
    endfunction

    logic [47:0] m_p    [3];
    logic [7:0]  m_co   [3];
    bit          m_pd   [3];
    bit          m_pbd  [3];
    bit          m_pdp  [3];
    bit          m_pbdp [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || rstp) begin
            for (int i = 0; i < 3; i++) begin
                m_p[i] <= '0; m_co[i] <= '0; m_pd[i] <= 0;
                m_pbd[i] <= 0; m_pdp[i] <= 0; m_pbdp[i] <= 0;
            end
        end else if (cep) begin
            for (int i = 0; i < 3; i++) begin
                if ((i == 1 && m_pd[i]) || (i == 2 && !m_pd[i])) begin
                    m_p[i] <= '0; m_co[i] <= '0;
                end else begin
                    m_p[i] <= s; m_co[i] <= f_cin(use_simd, rsc, cout);
                end
                m_pd[i]   <= f_det(s, pattern, mask);
                m_pbd[i]  <= f_detb(s, pattern, mask);
                m_pdp[i]  <= m_pd[i];
                m_pbdp[i] <= m_pbd[i];
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("m_p%0d", i),    64'(p_o[i]),    64'(m_p[i]));
                chk($sformatf("m_co%0d", i),   64'(co_o[i]),   64'(m_co[i]));
                chk($sformatf("m_pd%0d", i),   64'(pd_o[i]),   64'(m_pd[i]));
                chk($sformatf("m_pbd%0d", i),  64'(pbd_o[i]),  64'(m_pbd[i]));
                chk($sformatf("m_pdp%0d", i),  64'(pdp_o[i]),  64'(m_pdp[i]));
                chk($sformatf("m_pbdp%0d", i), 64'(pbdp_o[i]), 64'(m_pbdp[i]));
                chk($sformatf("m_ovf%0d", i),  64'(ovf_o[i]),
                    64'(m_pdp[i] & !m_pd[i] & !m_pbd[i]));
                chk($sformatf("m_unf%0d", i),  64'(unf_o[i]),
                    64'(m_pbdp[i] & !m_pd[i] & !m_pbd[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [47:0] rnd48();
        return 48'({$urandom(), $urandom()});
    endfunction

    initial begin
        rst_n = 1'b0; cep = 1'b1; rstp = 1'b0; use_simd = 2'b00;
        s = 48'h0000_1234_5678; cout = 1'b0; rsc = '0;
        pattern = 48'hFFFF_FFFF_FFFF; mask = '0;
        chk_en = 1'b1;
        repeat (2) step();
        chk("rst_p", 64'(p_o[0]), 64'h0);
        chk("rst_flags", 64'({pd_o[0], pbd_o[0], pdp_o[0], pbdp_o[0], ovf_o[0], unf_o[0]}), 64'h0);
        rst_n = 1'b1;
        chk("pre_edge_p", 64'(p_o[0]), 64'h0);
        step();
        chk("load_p", 64'(p_o[0]), 64'h0000_1234_5678);
        chk("load_pd_pbd", 64'({pd_o[0], pbd_o[0]}), 64'h0);

        // Overflow then underflow
        mask = 48'h0000_FFFF_FFFF; pattern = '0; s = 48'h0000_0000_0001;
        step();
        chk("ovf_pd1", 64'(pd_o[0]), 64'h1);
        s = 48'h0001_0000_0000;
        step();
        chk("ovf_pd_pbd", 64'({pd_o[0], pbd_o[0]}), 64'h0);
        chk("ovf_pdp", 64'(pdp_o[0]), 64'h1);
        chk("ovf_flag", 64'(ovf_o[0]), 64'h1);
        s = 48'hFFFF_0000_0000;
        step();
        chk("unf_pbd", 64'(pbd_o[0]), 64'h1);
        s = 48'hFFFE_0000_0000;
        step();
        chk("unf_flag", 64'(unf_o[0]), 64'h1);
        chk("unf_ovf0", 64'(ovf_o[0]), 64'h0);

        // Auto-reset on detect (dut1) and on no-detect (dut2)
        pattern = 48'd100; mask = '0; s = 48'd99;
        step();
        s = 48'd100;
        step();
        chk("ar1_p100", 64'(p_o[1]), 64'd100);
        chk("ar1_pd", 64'(pd_o[1]), 64'h1);
        chk("ar2_p0", 64'(p_o[2]), 64'h0);
        s = 48'd101;
        step();
        chk("ar1_cleared", 64'(p_o[1]), 64'h0);
        chk("ar0_p101", 64'(p_o[0]), 64'd101);
        chk("ar2_p101", 64'(p_o[2]), 64'd101);
        s = 48'd102;
        step();
        chk("ar1_p102", 64'(p_o[1]), 64'd102);
        chk("ar2_p0b", 64'(p_o[2]), 64'h0);

        // SIMD carry mapping
        use_simd = 2'b11; rsc = 16'h5555;
        step();
        chk("simd8", 64'(co_o[0]), 64'hFF);
        use_simd = 2'b01; rsc = 16'h4040;
        step();
        chk("simd2", 64'(co_o[0]), 64'h88);
        use_simd = 2'b00; rsc = '0; cout = 1'b1;
        step();
        chk("simd1", 64'(co_o[0]), 64'h80);

        // Enable hold, RSTP without CEP, async reset between edges
        s = 48'h0000_0000_ABCD;
        step();
        chk("hold_load", 64'(p_o[0]), 64'hABCD);
        cep = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s = rnd48(); cout = 1'b0;
            step();
            chk("hold_p", 64'(p_o[0]), 64'hABCD);
            chk("hold_co", 64'(co_o[0]), 64'h80);
        end
        rstp = 1'b1;
        step();
        chk("rstp_p", 64'(p_o[0]), 64'h0);
        chk("rstp_co", 64'(co_o[0]), 64'h0);
        rstp = 1'b0; cep = 1'b1; s = 48'd5;
        step();
        chk("post_rstp", 64'(p_o[0]), 64'd5);
        rst_n = 1'b0;
        #1;
        chk("async_p", 64'(p_o[0]), 64'h0);
        rst_n = 1'b1;
        step();
        chk("rel_p", 64'(p_o[0]), 64'd5);
        chk("rel_pdp", 64'(pdp_o[0]), 64'h0);

        // Randomised traffic, biased toward pattern hits
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                pattern = rnd48();
                mask = ($urandom_range(0, 9) == 0) ? 48'hFFFF_FFFF_FFFF : (rnd48() & rnd48());
            end
            case ($urandom_range(0, 3))
                0:       s = pattern ^ (rnd48() & mask);
                1:       s = ~pattern ^ (rnd48() & mask);
                default: s = rnd48();
            endcase
            use_simd = 2'($urandom_range(0, 3));
            rsc = 16'($urandom());
            cout = 1'($urandom());
            cep = ($urandom_range(0, 9) != 0);
            rstp = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            step();
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_output_register_pattern_detect.md
# alu_output_register_pattern_detect

Output stage directly downstream of the SIMD ALU. It registers the 48-bit ALU sum and the carry-outs into the P register, and runs a masked pattern/inverted-pattern detector aligned with P. It also produces overflow/underflow flags from the current and previous-cycle detect results, and applies optional auto-reset of P on a detect condition. P feeds back to the upstream operand muxes for accumulation.

## Interface
- `AUTORESET_PATDET`, default 2'b00 — 00 no auto-reset; 01 reset P on PATTERNDETECT; 10 reset P on not-PATTERNDETECT; 11 illegal, behaves as 00.
- `clk`  in  1  — single clock; all state on rising edge.
- `rst_n`  in  1  — asynchronous, active-low reset.
- `CEP`  in  1  — clock enable for all registers.
- `RSTP`  in  1  — synchronous active-high reset of all registers, gated by nothing (acts even when CEP=0).
- `USE_SIMD`  in  2  — 00 27x18 (one 48-bit lane); 01 two lanes; 10 four lanes; 11 eight lanes.
- `S`  in  48  — ALU sum.
- `COUT`  in  1  — ALU full-width carry-out.
- `result_SIMD_carry_out`  in  16  — ALU per-segment carries; bit 2k is the carry of segment k.
- `PATTERN`  in  48  — compare pattern, quasi-static.
- `MASK`  in  48  — 1 = bit ignored in compare, quasi-static.
- `P`  out  48  — registered result.
- `CARRYOUT`  out  8  — registered per-lane carries.
- `PATTERNDETECT`  out  1  — registered: masked S == PATTERN.
- `PATTERNBDETECT`  out  1  — registered: masked S == ~PATTERN.
- `PATTERNDETECT_PAST`, `PATTERNBDETECT_PAST`  out  1 each  — previous values of the two flags.
- `OVERFLOW`, `UNDERFLOW`  out  1 each  — combinational from the registered flags.

## Operation
- Detect, computed from S combinationally:
  - det = &(~(S ^ PATTERN) | MASK)
  - detb = &((S ^ PATTERN) | MASK)
  - MASK all ones gives det = detb = 1.
- CARRYOUT lane map, computed as cin_next:
  - USE_SIMD 00: bit7 = COUT, others 0.
  - 01: bit3 = rsc[6], bit7 = rsc[14].
  - 10: bits 1,3,5,7 = rsc[2],rsc[6],rsc[10],rsc[14].
  - 11: bit k = rsc[2k].
  - Unlisted bits are 0. rsc = result_SIMD_carry_out.
- Register update, by priority:
  1. rst_n=0 (asynchronous): all registers to 0.
  2. RSTP=1: all registers to 0.
  3. CEP=1 and auto-reset active: P and CARRYOUT to 0. Detect flags still load det/detb, and the past flags still shift.
  4. CEP=1: P<=S, CARRYOUT<=cin_next, PATTERNDETECT<=det, PATTERNBDETECT<=detb, and each _PAST<=its old flag.
  5. Otherwise, hold.
- Auto-reset active means:
  - AUTORESET_PATDET=01 and PATTERNDETECT (registered) = 1.
  - AUTORESET_PATDET=10 and PATTERNDETECT (registered) = 0.
- Flags:
  - OVERFLOW = PATTERNDETECT_PAST & ~PATTERNDETECT & ~PATTERNBDETECT.
  - UNDERFLOW = PATTERNBDETECT_PAST & ~PATTERNDETECT & ~PATTERNBDETECT.
- Widths: no arithmetic in this stage; S is passed unmodified. Lane boundaries are used only for carries.

## Timing
- Latency is 1 cycle from S/COUT to P/CARRYOUT/detect flags, which are always mutually aligned.
- _PAST flags are 1 CEP-enabled cycle behind the flags. OVERFLOW/UNDERFLOW are valid in the same cycle as P.
- CEP=0: every output holds, including the _PAST flags. Auto-reset waits for the next CEP=1 edge.
- Auto-reset clears P on the edge after the detect flag is registered, i.e. P is 0 two edges after the matching S.
- RSTP during auto-reset: RSTP wins; the flags clear too.
- rst_n deassertion mid-stream: the first CEP edge after release loads normally; the _PAST flags read 0.
- Reset value of every output is 0. After reset, OVERFLOW=UNDERFLOW=0.
- Changing USE_SIMD takes effect on the next CEP edge; there is no pipelined mode register.

## Test plan
- Reset/load: rst_n=0 then release, CEP=1, S=48'h0000_1234_5678 -> all outputs 0 before the edge; after 1 edge P=48'h0000_1234_5678, flags 0 with PATTERN=48'hFFFF_FFFF_FFFF, MASK=0.
- Overflow: MASK=48'h0000_FFFF_FFFF, PATTERN=0; S sequence 48'h0000_0000_0001 then 48'h0001_0000_0000 -> edge1 PATTERNDETECT=1; edge2 PATTERNDETECT=0, PATTERNBDETECT=0, PATTERNDETECT_PAST=1, OVERFLOW=1. S=48'hFFFE_0000_0000 after detb -> UNDERFLOW=1.
- Auto-reset: AUTORESET_PATDET=01, PATTERN=48'd100, MASK=0, S stepping 99,100,101 -> P=100 with PATTERNDETECT=1; next edge P=0 although S=101.
- SIMD carries: USE_SIMD=11, rsc=16'h5555 -> CARRYOUT=8'hFF. USE_SIMD=01, rsc=16'h4040 -> 8'h88. USE_SIMD=00, COUT=1 -> 8'h80.
- Enable/priority: CEP=0 for 3 cycles while S changes -> all outputs frozen. RSTP=1 with CEP=0 -> all registers 0 on the next edge. Assert rst_n=0 between edges -> outputs 0 immediately.
